// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the hex scan display.
// Segment bit 0 is CA and bit 6 is CG. All patterns are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational decoder from one hex nibble to its seven-segment cathode pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        unique case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display driver with registered anode/cathode outputs.
// Define HEX_SCAN_LZB_EN to enable leading-zero blanking.
module hex_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        LOAD,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [3:0]  AN
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    logic [15:0]   r_data;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic [15:0]   w_data_d;
    logic [PW-1:0] w_presc_d;
    logic [1:0]    w_idx_d;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_hex;
    logic          w_blank;
    logic [3:0]    w_an_d;
    logic [6:0]    w_seg_d;

    // Outputs are computed from next-state so a capture or digit change shows on the same edge.
    assign w_wrap    = (r_presc == PRESC_MAX);
    assign w_data_d  = LOAD ? DATA : r_data;
    assign w_presc_d = w_wrap ? '0 : r_presc + PW'(1);
    assign w_idx_d   = w_wrap ? r_idx + 2'd1 : r_idx;
    assign w_nibble  = w_data_d[{w_idx_d, 2'b00} +: 4];

`ifdef HEX_SCAN_LZB_EN
    assign w_blank = (w_idx_d != 2'd0) && ((w_data_d >> {w_idx_d, 2'b00}) == 16'h0000);
`else
    assign w_blank = 1'b0;
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_hex)
    );

    always_comb begin
        w_an_d  = AN_OFF;
        w_seg_d = SEG_OFF;
        if (!w_blank) begin
            w_an_d  = ~(4'b0001 << w_idx_d);
            w_seg_d = w_seg_hex;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_data  <= 16'h0000;
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_OFF;
        end else begin
            r_data  <= w_data_d;
            r_presc <= w_presc_d;
            r_idx   <= w_idx_d;
            r_an    <= w_an_d;
            r_seg   <= w_seg_d;
        end
    end

    assign SEG = r_seg;
    assign AN  = r_an;
    assign DP  = 1'b1;

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display using a cycle-count reference model.
module tb_hex_scan_display;

    localparam int unsigned RD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_vec = 0;
    int n_err = 0;

    // Model state: edges since reset release, and the captured value.
    int          m_edges = 0;
    bit          m_in_rst = 1'b1;
    logic [15:0] m_data = 16'h0000;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    hex_scan_display #(
        .REFRESH_DIV (RD)
    ) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .DATA      (data),
        .LOAD      (load),
        .SEG       (seg),
        .DP        (dp),
        .AN        (an)
    );

    function automatic int m_idx();
        return (m_edges / RD) % 4;
    endfunction

    function automatic logic [11:0] m_expect();
        int   k;
        logic [3:0] nib;
        bit   blank;
        if (m_in_rst) return {4'b1111, 7'b1111111, 1'b1};
        k     = m_idx();
        nib   = 4'((m_data >> (4 * k)) & 16'hF);
        blank = 1'b0;
`ifdef HEX_SCAN_LZB_EN
        blank = (k > 0) && ((m_data >> (4 * k)) == 16'h0000);
`endif
        if (blank) return {4'b1111, 7'b1111111, 1'b1};
        return {~(4'b0001 << k), tbl[nib], 1'b1};
    endfunction

    task automatic step(input string tag);
        logic [11:0] exp_v;
        @(posedge clk);
        if (rst) begin
            m_in_rst = 1'b1;
            m_edges  = 0;
            m_data   = 16'h0000;
        end else begin
            if (load) m_data = data;
            m_in_rst = 1'b0;
            m_edges++;
        end
        #1;
        exp_v = m_expect();
        n_vec++;
        assert ({an, seg, dp} === exp_v) else begin
            n_err++;
            $error("FAIL %s: AN/SEG/DP got %b/%b/%b exp %b/%b/%b", tag, an, seg, dp,
                   exp_v[11:8], exp_v[7:1], exp_v[0]);
        end
        n_vec++;
        assert ($countones(~an) <= 1) else begin
            n_err++;
            $error("FAIL %s_onehot: AN got %b exp at most one low bit", tag, an);
        end
    endtask

    task automatic check_raw(input string tag, input logic [3:0] an_exp,
                             input logic [6:0] seg_exp);
        n_vec++;
        assert (an === an_exp && seg === seg_exp) else begin
            n_err++;
            $error("FAIL %s: AN/SEG got %b/%b exp %b/%b", tag, an, seg, an_exp, seg_exp);
        end
    endtask

    initial begin
        int guard;
        rst  = 1'b1;
        load = 1'b0;
        data = 16'h0000;

        for (int i = 0; i < 3; i++) step("reset_hold");
        check_raw("reset_off", 4'b1111, 7'b1111111);

        rst = 1'b0;
        step("release");
        check_raw("first_edge", 4'b1110, 7'b1000000);

        load = 1'b1;
        data = 16'h1234;
        step("load_1234");
        load = 1'b0;
        data = 16'hFFFF;
        for (int i = 0; i < 3 * 4 * RD; i++) step("hold_1234");

        guard = 0;
        while (m_idx() != 2 && guard < 8 * RD) begin
            step("seek_idx2");
            guard++;
        end
        n_vec++;
        assert (m_idx() == 2) else begin
            n_err++;
            $error("FAIL seek_idx2_timeout: idx got %0d exp 2", m_idx());
        end
        rst = 1'b1;
        step("mid_reset");
        check_raw("mid_reset_off", 4'b1111, 7'b1111111);
        rst = 1'b0;
        for (int i = 0; i < RD - 1; i++) step("restart");

        load = 1'b1;
        data = 16'hBEEF;
        step("wrap_load");
        check_raw("wrap_load_e", 4'b1101, 7'b0000110);
        load = 1'b0;
        for (int i = 0; i < 4 * RD; i++) step("show_beef");

        load = 1'b1;
        data = 16'h00A5;
        step("load_00a5");
        load = 1'b0;
        for (int i = 0; i < 4 * RD; i++) step("show_00a5");
        load = 1'b1;
        data = 16'h0000;
        step("load_0000");
        load = 1'b0;
        for (int i = 0; i < 4 * RD; i++) step("show_0000");

        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 3) == 0);
            data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) data = data & 16'h00FF;
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
